// File: rtl/multicycle_controller.sv
// multicycle_controller: main FSM plus ALU and immediate decoders for the
// shared-memory multicycle RV32I datapath (lw, sw, R-type, I-type ALU, beq, jal).
// Optional build macro PERF_CNT_EN adds cycle and retired-instruction counters.
// Without it, CycleCnt and InstRet are tied to 0.
module multicycle_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic [2:0]       ALUControl,
    output logic [1:0]       ImmSrc,
    output logic             Illegal,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] InstRet
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
    } state_t;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       pc_update;
        logic       branch;
        logic       decode;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl_q;
    ctrl_t  cur;
    logic   op_ok;

    // Moore control word for a given state; unlisted fields stay 0
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.ir_write = 1'b1; c.pc_update = 1'b1;
                            c.alu_src_b = 2'b10; c.result_src = 2'b10; end
            DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.decode = 1'b1; end
            MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            MEMREAD:  begin c.adr_src = 1'b1; end
            MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
            EXECUTER: begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
            EXECUTEI: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
            ALUWB:    begin c.reg_write = 1'b1; end
            BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
            JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    // Sequencing; DECODE dispatches on op, MEMADR splits lw/sw on op[5]
    function automatic state_t next_of(input state_t s, input logic [6:0] o);
        state_t n;
        n = FETCH;
        case (s)
            FETCH:  n = DECODE;
            DECODE: begin
                case (o)
                    OP_LW, OP_SW: n = MEMADR;
                    OP_R:         n = EXECUTER;
                    OP_I:         n = EXECUTEI;
                    OP_BEQ:       n = BEQ;
                    OP_JAL:       n = JAL;
                    default:      n = FETCH;
                endcase
            end
            MEMADR:             n = o[5] ? MEMWRITE : MEMREAD;
            MEMREAD:            n = MEMWB;
            EXECUTER, EXECUTEI: n = ALUWB;
            JAL:                n = ALUWB;
            default:            n = FETCH;
        endcase
        return n;
    endfunction

    // Next-state selection
    always_comb begin
        state_nxt = next_of(state, op);
    end

    // State register with the control word registered alongside it
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH;
            ctrl_q <= ctrl_of(FETCH);
        end else begin
            state  <= state_nxt;
            ctrl_q <= ctrl_of(state_nxt);
        end
    end

    // While reset is held, present FETCH selects with every strobe cleared
    always_comb begin
        cur = ctrl_q;
        if (reset) begin
            cur           = ctrl_of(FETCH);
            cur.ir_write  = 1'b0;
            cur.pc_update = 1'b0;
        end
    end

    assign op_ok = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                   (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);

    assign AdrSrc    = cur.adr_src;
    assign MemWrite  = cur.mem_write;
    assign IRWrite   = cur.ir_write;
    assign RegWrite  = cur.reg_write;
    assign ResultSrc = cur.result_src;
    assign ALUSrcA   = cur.alu_src_a;
    assign ALUSrcB   = cur.alu_src_b;
    assign PCWrite   = cur.pc_update | (cur.branch & Zero);
    assign Illegal   = cur.decode & ~op_ok;

    // ALU operation decode from ALUOp and the function fields
    always_comb begin
        ALUControl = 3'b000;
        case (cur.alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format select from opcode
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] inst_ret;

    // Free-running cycle count and retirement on exit from a final state
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            inst_ret  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (state == MEMWB || state == MEMWRITE || state == ALUWB || state == BEQ) begin
                inst_ret <= inst_ret + CNT_W'(1);
            end
        end
    end

    assign CycleCnt = cycle_cnt;
    assign InstRet  = inst_ret;
`else
    assign CycleCnt = '0;
    assign InstRet  = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized instruction stream against an
// instruction-level model of the multicycle controller's per-cycle control.
module tb_multicycle_controller;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4, C_JAL = 5, C_ILL = 6;

    logic        clk;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Zero;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUControl;
    logic [31:0] CycleCnt, InstRet;

    logic [31:0] obs;
    logic [31:0] exp_cyc;
    logic [31:0] exp_ret;
    logic [6:0]  rop;
    int          checks;
    int          failures;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .RegWrite(RegWrite), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
        .Illegal(Illegal), .CycleCnt(CycleCnt), .InstRet(InstRet)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = 32'({PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                      ALUSrcB, RegWrite, ALUControl, Illegal});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic int classify(input logic [6:0] o);
        case (o)
            OP_LW:   return C_LW;
            OP_SW:   return C_SW;
            OP_R:    return C_R;
            OP_I:    return C_I;
            OP_BEQ:  return C_BEQ;
            OP_JAL:  return C_JAL;
            default: return C_ILL;
        endcase
    endfunction

    function automatic int latency(input int cls);
        case (cls)
            C_LW:    return 5;
            C_BEQ:   return 3;
            C_ILL:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [1:0] imm_for(input int cls);
        case (cls)
            C_SW:    return 2'b01;
            C_BEQ:   return 2'b10;
            C_JAL:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // ALU op wanted by an R/I instruction: add/sub/slt/or/and by funct3
    function automatic logic [2:0] alu_for(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (o[5] && f7) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected control bundle in cycle k of an instruction of class cls
    function automatic logic [31:0] expect_ctrl(input int cls, input int k, input logic [6:0] o,
                                                input logic [2:0] f3, input logic f7,
                                                input logic z, input logic rst);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb;
        logic [2:0] ac;
        pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; ill = 1'b0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; ac = 3'b000;
        if (rst) begin
            sb = 2'b10; rs = 2'b10;
        end else if (k == 0) begin
            irw = 1'b1; pcw = 1'b1; sb = 2'b10; rs = 2'b10;
        end else if (k == 1) begin
            sa = 2'b01; sb = 2'b01; ill = (cls == C_ILL);
        end else begin
            case (cls)
                C_LW: begin
                    if (k == 2) begin sa = 2'b10; sb = 2'b01; end
                    if (k == 3) adr = 1'b1;
                    if (k == 4) begin rs = 2'b01; rw = 1'b1; end
                end
                C_SW: begin
                    if (k == 2) begin sa = 2'b10; sb = 2'b01; end
                    if (k == 3) begin adr = 1'b1; mw = 1'b1; end
                end
                C_R, C_I: begin
                    if (k == 2) begin
                        sa = 2'b10; sb = (cls == C_I) ? 2'b01 : 2'b00; ac = alu_for(o, f3, f7);
                    end
                    if (k == 3) rw = 1'b1;
                end
                C_BEQ: begin
                    sa = 2'b10; ac = 3'b001; pcw = z;
                end
                C_JAL: begin
                    if (k == 2) begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
                    if (k == 3) rw = 1'b1;
                end
                default: ;
            endcase
        end
        return 32'({pcw, adr, mw, irw, rs, sa, sb, rw, ac, ill});
    endfunction

    task automatic check_counters();
`ifdef PERF_CNT_EN
        check("cyclecnt", CycleCnt, exp_cyc);
        check("instret", InstRet, exp_ret);
`else
        check("cyclecnt", CycleCnt, 32'd0);
        check("instret", InstRet, 32'd0);
`endif
    endtask

    // Hold reset for the given number of edges, checking the quiet reset bundle
    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            exp_cyc = 32'd0;
            exp_ret = 32'd0;
            check("rst_ctrl", obs, expect_ctrl(C_LW, 0, op, funct3, funct7b5, Zero, 1'b1));
            check_counters();
        end
        reset = 1'b0;
    endtask

    // Run one instruction; zsel 0/1 fixes Zero, 2 randomizes it each cycle
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input int zsel);
        int cls;
        int n;
        cls = classify(o);
        n = latency(cls);
        op = o; funct3 = f3; funct7b5 = f7;
        for (int k = 0; k < n; k++) begin
            Zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            #1;
            check($sformatf("ctrl op=%b k=%0d", o, k), obs,
                  expect_ctrl(cls, k, o, f3, f7, Zero, 1'b0));
            check($sformatf("imm op=%b", o), 32'(ImmSrc), 32'(imm_for(cls)));
            check_counters();
            @(posedge clk);
            exp_cyc = exp_cyc + 32'd1;
            if (k == n - 1 && cls != C_ILL) exp_ret = exp_ret + 32'd1;
            #1;
        end
    endtask

    // Start a lw and pull reset during MEMREAD: no write may follow
    task automatic abort_lw();
        op = OP_LW; funct3 = 3'd2; funct7b5 = 1'b0; Zero = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("abort_ctrl k=%0d", k), obs,
                  expect_ctrl(C_LW, k, OP_LW, 3'd2, 1'b0, 1'b0, 1'b0));
            if (k < 3) begin
                @(posedge clk);
                exp_cyc = exp_cyc + 32'd1;
                #1;
            end
        end
        reset = 1'b1;
        #1;
        check("abort_rst_ctrl", obs, expect_ctrl(C_LW, 0, OP_LW, 3'd2, 1'b0, 1'b0, 1'b1));
        check("abort_regwrite", 32'(RegWrite), 32'd0);
        do_reset(1);
        check("abort_regwrite_after", 32'(RegWrite), 32'd0);
    endtask

    initial begin
        checks = 0; failures = 0;
        exp_cyc = 32'd0; exp_ret = 32'd0;
        reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
        do_reset(2);

        run_instr(OP_LW, 3'd2, 1'b0, 2);
        run_instr(OP_SW, 3'd2, 1'b0, 2);
        run_instr(OP_R, 3'd0, 1'b0, 2);
        run_instr(OP_BEQ, 3'd0, 1'b0, 1);
`ifdef PERF_CNT_EN
        check("perf_cycles16", CycleCnt, 32'd16);
        check("perf_instret4", InstRet, 32'd4);
`endif

        run_instr(OP_R, 3'd0, 1'b1, 2);
        run_instr(OP_I, 3'd0, 1'b1, 2);
        run_instr(OP_BEQ, 3'd0, 1'b0, 0);
        run_instr(OP_JAL, 3'd0, 1'b0, 2);
        run_instr(7'b1111111, 3'd0, 1'b0, 2);
        run_instr(OP_R, 3'd2, 1'b0, 2);
        abort_lw();
        run_instr(OP_LW, 3'd2, 1'b0, 2);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 6))
                0:       rop = OP_LW;
                1:       rop = OP_SW;
                2:       rop = OP_R;
                3:       rop = OP_I;
                4:       rop = OP_BEQ;
                5:       rop = OP_JAL;
                default: rop = 7'($urandom);
            endcase
            run_instr(rop, 3'($urandom), 1'($urandom), 2);
            if (i % 60 == 59) do_reset(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
